// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS channel word aligner and 8b/10b symbol decoder
// Optional lock-loss statistics counter enabled by defining TMDS_DEC_STATS_EN.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT = 8,
  parameter int MAX_GAP    = 4095
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  tmds_raw,
  output logic [7:0]  data,
  output logic [1:0]  ctrl,
  output logic        de,
  output logic        ctrl_valid,
  output logic        locked,
  output logic [3:0]  offset,
  output logic        lock_loss,
  output logic [15:0] lock_loss_cnt
);

  localparam logic [7:0]  LOCK_COUNT_W = 8'(LOCK_COUNT);
  localparam logic [11:0] MAX_GAP_W    = 12'(MAX_GAP);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t      state, state_nxt;
  logic [3:0]  offset_nxt, offset_inc;
  logic [7:0]  run, run_nxt;
  logic [11:0] gap, gap_nxt, gap_inc;
  logic        loss_nxt, lock_hold;
  logic [9:0]  prev_raw;
  logic [18:0] pair;
  logic [9:0]  window;
  logic        is_tok;
  logic [1:0]  tok_ctrl;
  logic [9:0]  win_q;
  logic        tok_q;
  logic [1:0]  tok_ctrl_q;
  logic [7:0]  dec_byte;
  logic [7:0]  d0;

  // Offsets only reach 9, so the top received bit never lands in a window.
  assign pair   = {tmds_raw[8:0], prev_raw};
  assign window = pair[{1'b0, offset} +: 10];

  always_comb begin
    is_tok   = 1'b1;
    tok_ctrl = 2'b00;
    case (window)
      10'b1101010100: tok_ctrl = 2'b00;
      10'b0010101011: tok_ctrl = 2'b01;
      10'b0101010100: tok_ctrl = 2'b10;
      10'b1010101011: tok_ctrl = 2'b11;
      default:        is_tok   = 1'b0;
    endcase
  end

  assign offset_inc = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
  assign gap_inc    = gap + 12'd1;

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    run_nxt    = run;
    gap_nxt    = gap;
    loss_nxt   = 1'b0;
    case (state)
      SEARCH: begin
        if (is_tok) begin
          state_nxt = VERIFY;
          run_nxt   = 8'd1;
        end else begin
          offset_nxt = offset_inc;
        end
      end
      VERIFY: begin
        if (is_tok) begin
          run_nxt = run + 8'd1;
          if (run_nxt == LOCK_COUNT_W) begin
            state_nxt = LOCKED;
            gap_nxt   = 12'd0;
          end
        end else begin
          state_nxt  = SEARCH;
          offset_nxt = offset_inc;
          run_nxt    = 8'd0;
        end
      end
      LOCKED: begin
        // A token on the expiry cycle wins and keeps the lock.
        if (is_tok) begin
          gap_nxt = 12'd0;
        end else if (gap_inc == MAX_GAP_W) begin
          state_nxt = SEARCH;
          gap_nxt   = 12'd0;
          run_nxt   = 8'd0;
          loss_nxt  = 1'b1;
        end else begin
          gap_nxt = gap_inc;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  assign lock_hold = (state == LOCKED) && (state_nxt == LOCKED);

  always_comb begin
    d0          = win_q[9] ? ~win_q[7:0] : win_q[7:0];
    dec_byte    = 8'h00;
    dec_byte[0] = d0[0];
    for (int i = 1; i < 8; i++) begin
      dec_byte[i] = win_q[8] ? (d0[i] ^ d0[i-1]) : ~(d0[i] ^ d0[i-1]);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state      <= SEARCH;
      offset     <= 4'd0;
      run        <= 8'd0;
      gap        <= 12'd0;
      prev_raw   <= 10'd0;
      win_q      <= 10'd0;
      tok_q      <= 1'b0;
      tok_ctrl_q <= 2'b00;
      data       <= 8'h00;
      ctrl       <= 2'b00;
      de         <= 1'b0;
      ctrl_valid <= 1'b0;
      locked     <= 1'b0;
      lock_loss  <= 1'b0;
    end else begin
      state      <= state_nxt;
      offset     <= offset_nxt;
      run        <= run_nxt;
      gap        <= gap_nxt;
      prev_raw   <= tmds_raw;
      win_q      <= window;
      tok_q      <= is_tok;
      tok_ctrl_q <= tok_ctrl;
      locked     <= lock_hold;
      lock_loss  <= loss_nxt;
      if (lock_hold) begin
        de         <= ~tok_q;
        ctrl_valid <= tok_q;
        ctrl       <= tok_q ? tok_ctrl_q : 2'b00;
        data       <= tok_q ? 8'h00 : dec_byte;
      end else begin
        de         <= 1'b0;
        ctrl_valid <= 1'b0;
        ctrl       <= 2'b00;
        data       <= 8'h00;
      end
    end
  end

`ifdef TMDS_DEC_STATS_EN
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      lock_loss_cnt <= 16'h0000;
    end else if (loss_nxt && (lock_loss_cnt != 16'hFFFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 16'h0001;
    end
  end
`else
  assign lock_loss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - directed-vector bench for tmds_channel_decoder
module tb_tmds_channel_decoder;

  localparam int LOCK_COUNT = 8;
  localparam int MAX_GAP    = 4095;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;

  logic        clk_pixel = 1'b0;
  logic        reset     = 1'b1;
  logic [9:0]  tmds_raw  = 10'd0;
  logic [7:0]  data;
  logic [1:0]  ctrl;
  logic        de;
  logic        ctrl_valid;
  logic        locked;
  logic [3:0]  offset;
  logic        lock_loss;
  logic [15:0] lock_loss_cnt;

  tmds_channel_decoder #(.LOCK_COUNT(LOCK_COUNT), .MAX_GAP(MAX_GAP)) dut (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .tmds_raw     (tmds_raw),
    .data         (data),
    .ctrl         (ctrl),
    .de           (de),
    .ctrl_valid   (ctrl_valid),
    .locked       (locked),
    .offset       (offset),
    .lock_loss    (lock_loss),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk_pixel = ~clk_pixel;

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          rot       = 0;
  int          loss_seen = 0;
  logic [9:0]  last_sym  = T0;

  // Data-period vectors: symbol, decoded byte, control symbol flag, control bits.
  logic [9:0] vec_sym  [8] = '{10'h100, 10'h1FF, 10'h2AA, 10'h0F0, T1, T2, T3, T0};
  logic [7:0] vec_data [8] = '{8'h00, 8'h01, 8'h01, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h00};
  logic       vec_tok  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [1:0] vec_ctrl [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serialise one symbol into the stream, shifted later by rot bit positions.
  task automatic send(input logic [9:0] sym);
    logic [19:0] pr;
    pr       = {sym, last_sym};
    pr       = pr >> (10 - rot);
    tmds_raw = pr[9:0];
    last_sym = sym;
    @(posedge clk_pixel);
    #1;
    if (lock_loss) loss_seen++;
  endtask

  task automatic do_reset(input int r);
    reset = 1'b1;
    repeat (3) begin
      tmds_raw = 10'($urandom);
      @(posedge clk_pixel);
      #1;
      if (lock_loss) loss_seen++;
    end
    reset    = 1'b0;
    rot      = r;
    last_sym = T0;
  endtask

  task automatic wait_lock(input string tag, input int exp_sends);
    int n;
    n = 0;
    while (!locked && n < 100) begin
      send(T0);
      n++;
    end
    check({tag, "_locked"}, 32'(locked), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_sends));
  endtask

  initial begin
    int first_loss;
    int locked_at_loss;
    int exp_cnt;
`ifdef TMDS_DEC_STATS_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif

    for (int i = 0; i < 5; i++) begin
      tmds_raw = 10'($urandom);
      @(posedge clk_pixel);
      #1;
      check("reset_outputs", {18'd0, data, ctrl, de, ctrl_valid, locked, lock_loss}, 32'd0);
      check("reset_offset", 32'(offset), 32'd0);
      check("reset_cnt", 32'(lock_loss_cnt), 32'd0);
    end
    reset    = 1'b0;
    rot      = 0;
    last_sym = T0;

    // Offset 0 window is prev_raw (zero after reset), so one full offset sweep precedes the token run.
    wait_lock("aligned", 11 + LOCK_COUNT);
    check("aligned_offset", 32'(offset), 32'd0);
    check("aligned_ctrl_valid", 32'(ctrl_valid), 32'd1);
    check("aligned_ctrl", 32'(ctrl), 32'd0);
    check("aligned_de", 32'(de), 32'd0);

    for (int i = 0; i < 10; i++) begin
      send((i < 8) ? vec_sym[i] : T0);
      if (i >= 2) begin
        check($sformatf("vec%0d_de", i - 2), 32'(de), 32'(!vec_tok[i-2]));
        check($sformatf("vec%0d_ctrl_valid", i - 2), 32'(ctrl_valid), 32'(vec_tok[i-2]));
        check($sformatf("vec%0d_data", i - 2), 32'(data), 32'(vec_data[i-2]));
        check($sformatf("vec%0d_ctrl", i - 2), 32'(ctrl), 32'(vec_ctrl[i-2]));
      end
    end

    // A token lands exactly when the gap timer would expire; lock must hold.
    repeat (MAX_GAP - 1) send(10'h100);
    send(T0);
    loss_seen      = 0;
    first_loss     = 0;
    locked_at_loss = 1;
    for (int k = 1; k <= MAX_GAP + 3; k++) begin
      send(10'h100);
      if (k == 1) check("priority_locked", 32'(locked), 32'd1);
      if (k == 10) begin
        check("gap_stream_de", 32'(de), 32'd1);
        check("gap_stream_data", 32'(data), 32'h00);
      end
      if (lock_loss && first_loss == 0) begin
        first_loss     = k;
        locked_at_loss = int'(locked);
      end
    end
    check("loss_index", 32'(first_loss), 32'(MAX_GAP + 1));
    check("loss_pulses", 32'(loss_seen), 32'd1);
    check("locked_at_loss", 32'(locked_at_loss), 32'd0);
    check("unlocked_outputs", {20'd0, data, ctrl, de, ctrl_valid}, 32'd0);
    check("loss_cnt", 32'(lock_loss_cnt), 32'(exp_cnt));

    do_reset(3);
    wait_lock("rotated", 4 + LOCK_COUNT);
    check("rotated_offset", 32'(offset), 32'd3);
    for (int i = 0; i < 6; i++) begin
      send((i < 4) ? vec_sym[4 + i] : T0);
      if (i >= 2) begin
        check($sformatf("rot_tok%0d_valid", i - 2), 32'(ctrl_valid), 32'd1);
        check($sformatf("rot_tok%0d_ctrl", i - 2), 32'(ctrl), 32'(vec_ctrl[4 + i - 2]));
        check($sformatf("rot_tok%0d_offset", i - 2), 32'(offset), 32'd3);
      end
    end

    do_reset(0);
    wait_lock("relock", 11 + LOCK_COUNT);
    loss_seen = 0;
    do_reset(0);
    check("reset_locked_pulse", 32'(loss_seen), 32'd0);
    check("reset_locked_cnt", 32'(lock_loss_cnt), 32'd0);
    check("reset_locked_locked", 32'(locked), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
